// File: rtl/z80_io_ctrl.sv
// z80_io_ctrl: Z80 I/O decode (border write, keyboard read), per-frame
// maskable interrupt pulse generator and FLASH phase divider.
module z80_io_ctrl #(
    parameter int INT_LEN   = 3200,
    parameter int FLASH_DIV = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        n_iorq,
    input  logic        n_rd,
    input  logic        n_wr,
    input  logic        n_m1,
    input  logic        frame_start,
    input  logic [39:0] kbd_rows,
    output logic [7:0]  io_dout,
    output logic        io_oe,
    output logic [2:0]  border,
    output logic        n_int,
    output logic        flash
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // strobe vector order: {m1, wr, rd, iorq}
    logic [3:0]  sync1, sync2;
    logic        s_iorq, s_rd, s_wr, s_m1;
    logic [1:0]  settle;
    logic        wr_cond, wr_cond_q, wr_evt, rd_act, inta;
    logic [4:0]  k;
    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  fcnt;

    assign s_iorq = sync2[0];
    assign s_rd   = sync2[1];
    assign s_wr   = sync2[2];
    assign s_m1   = sync2[3];

    assign wr_cond = ~s_iorq & ~s_wr & s_m1;
    assign wr_evt  = wr_cond & ~wr_cond_q;
    assign rd_act  = ~s_iorq & ~s_rd & s_m1 & ~cpu_a[0];
    assign inta    = ~s_m1 & ~s_iorq;

    // two-flop synchronizers for the bus strobes, preset inactive
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= {n_m1, n_wr, n_rd, n_iorq};
            sync2 <= sync1;
        end
    end

    // write edge flop; held high until the sync chain reflects the real bus,
    // so a write strobe held low across reset must rise and fall to count
    always_ff @(posedge clk) begin
        if (reset) begin
            settle    <= 2'b00;
            wr_cond_q <= 1'b1;
        end else begin
            settle    <= {settle[0], 1'b1};
            wr_cond_q <= settle[1] ? wr_cond : 1'b1;
        end
    end

    // keyboard: AND of all half-rows whose address line A[8+i] is low
    always_comb begin
        k = 5'b11111;
        for (int i = 0; i < 8; i++) begin
            if (!cpu_a[8+i]) k = k & kbd_rows[5*i +: 5];
        end
    end

    // border register and registered read path
    always_ff @(posedge clk) begin
        if (reset) begin
            border  <= 3'd0;
            io_oe   <= 1'b0;
            io_dout <= 8'hFF;
        end else begin
            if (wr_evt && !cpu_a[0]) border <= cpu_d[2:0];
            io_oe   <= rd_act;
            io_dout <= rd_act ? {3'b111, k} : 8'hFF;
        end
    end

    // interrupt pulse FSM: timed nINT, cut short by acknowledge
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 16'd0;
            n_int <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= ACTIVE;
                        cnt   <= 16'(INT_LEN - 1);
                        n_int <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cnt == 16'd0 || inta) begin
                        state <= IDLE;
                        n_int <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    n_int <= 1'b1;
                end
            endcase
        end
    end

    // frame counter dividing frame_start into the FLASH phase
    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt  <= 8'd0;
            flash <= 1'b0;
        end else if (frame_start) begin
            if (fcnt == 8'(FLASH_DIV - 1)) begin
                fcnt  <= 8'd0;
                flash <= ~flash;
            end else begin
                fcnt <= fcnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_z80_io_ctrl.sv
// tb_z80_io_ctrl: vector table, randomized bus traffic against a reference
// model, and hand sequences for interrupt timing, FLASH and reset.
module tb_z80_io_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d;
    logic        n_iorq, n_rd, n_wr, n_m1;
    logic        frame_start;
    logic [39:0] kbd_rows;
    logic [7:0]  io_dout;
    logic        io_oe;
    logic [2:0]  border;
    logic        n_int;
    logic        flash;

    int errors = 0;
    int checks = 0;

    // reference state
    logic [2:0] m_border;
    int         m_frames;

    z80_io_ctrl #(.INT_LEN(3200), .FLASH_DIV(16)) dut (
        .clk(clk), .reset(reset), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr), .n_m1(n_m1),
        .frame_start(frame_start), .kbd_rows(kbd_rows),
        .io_dout(io_dout), .io_oe(io_oe), .border(border),
        .n_int(n_int), .flash(flash)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [15:0] a;
        logic [7:0]  d;
        logic [39:0] kbd;
        logic [2:0]  exp_border;
        logic        exp_oe;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_idle();
        n_iorq = 1'b1; n_rd = 1'b1; n_wr = 1'b1; n_m1 = 1'b1;
    endtask

    // a key bit reads 0 if that key is pressed in any selected half-row
    function automatic logic [4:0] kbd_ref(input logic [15:0] a, input logic [39:0] rows);
        logic [4:0] pressed;
        pressed = 5'b0;
        for (int b = 0; b < 5; b++)
            for (int r = 0; r < 8; r++)
                if (!a[8+r] && !rows[5*r+b]) pressed[b] = 1'b1;
        return ~pressed;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        m_border = 3'd0;
        m_frames = 0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        m_frames++;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        cpu_a = a; cpu_d = d;
        n_iorq = 1'b0; n_wr = 1'b0;
        steps(2);
        check("wr_before_3clk", border, m_border);
        step();
        if (!a[0]) m_border = d[2:0];
        check("wr_at_3clk", border, m_border);
        steps(17);
        bus_idle();
        steps(4);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [39:0] rows,
                           input logic exp_oe, input logic [7:0] exp_dout);
        kbd_rows = rows; cpu_a = a;
        n_iorq = 1'b0; n_rd = 1'b0;
        steps(3);
        check("rd_oe", io_oe, exp_oe);
        check("rd_dout", io_dout, exp_dout);
        steps(5);
        check("rd_dout_held", io_dout, exp_dout);
        bus_idle();
        steps(2);
        check("rd_oe_release_hold", io_oe, exp_oe);
        step();
        check("rd_oe_release", io_oe, 1'b0);
        check("rd_dout_release", io_dout, 8'hFF);
    endtask

    task automatic measure_int(input int extra_at, output int low);
        low = 1;
        for (int t = 0; t < 5000; t++) begin
            if (low == extra_at) pulse_frame();
            else step();
            if (n_int) break;
            low++;
        end
    endtask

    initial begin
        logic [63:0] rnd;
        logic [15:0] a;
        logic [39:0] rows;
        int low;

        vecs[0] = '{1'b0, 16'h00FE, 8'h05, 40'hFFFFFFFFFF, 3'd5, 1'b0, 8'hFF};
        vecs[1] = '{1'b0, 16'h00FF, 8'h02, 40'hFFFFFFFFFF, 3'd5, 1'b0, 8'hFF};
        vecs[2] = '{1'b1, 16'hFEFE, 8'h00, 40'hFFFFFFFFFE, 3'd5, 1'b1, 8'hFE};
        vecs[3] = '{1'b1, 16'h7EFE, 8'h00, 40'hBFFFFFFFFE, 3'd5, 1'b1, 8'hF6};
        vecs[4] = '{1'b1, 16'hFFFE, 8'h00, 40'hBFFFFFFFFE, 3'd5, 1'b1, 8'hFF};
        vecs[5] = '{1'b1, 16'h00FF, 8'h00, 40'h0000000000, 3'd5, 1'b0, 8'hFF};
        vecs[6] = '{1'b0, 16'h12FE, 8'hFA, 40'hFFFFFFFFFF, 3'd2, 1'b0, 8'hFF};

        bus_idle();
        cpu_a = 16'h0000; cpu_d = 8'h00; frame_start = 1'b0;
        kbd_rows = 40'hFFFFFFFFFF;
        do_reset();
        step();
        check("rst_border", border, 3'd0);
        check("rst_n_int", n_int, 1'b1);
        check("rst_io_oe", io_oe, 1'b0);
        check("rst_io_dout", io_dout, 8'hFF);
        check("rst_flash", flash, 1'b0);

        // vector table
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].rd) do_read(vecs[i].a, vecs[i].kbd, vecs[i].exp_oe, vecs[i].exp_dout);
            else            do_write(vecs[i].a, vecs[i].d);
            check("tbl_border", border, vecs[i].exp_border);
        end

        // randomized reads/writes against the model
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            a[0] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, 8'($urandom));
            end else begin
                rnd = {$urandom, $urandom};
                rows = rnd[39:0];
                do_read(a, rows, !a[0], a[0] ? 8'hFF : {3'b111, kbd_ref(a, rows)});
            end
            check("rnd_border", border, m_border);
        end

        // interrupt: plain pulse, then pulse with a frame_start 100 clk in
        pulse_frame();
        check("int_start", n_int, 1'b0);
        measure_int(-1, low);
        check("int_len", low, 3200);
        steps(5);
        pulse_frame();
        measure_int(100, low);
        check("int_len_not_extended", low, 3200);
        steps(5);

        // interrupt acknowledge at clk 500
        pulse_frame();
        steps(499);
        n_m1 = 1'b0; n_iorq = 1'b0;
        step();
        check("inta_1clk", n_int, 1'b0);
        step();
        check("inta_2clk", n_int, 1'b0);
        step();
        check("inta_3clk", n_int, 1'b1);
        bus_idle();
        steps(5);
        check("inta_border_untouched", border, m_border);
        pulse_frame();
        measure_int(-1, low);
        check("int_len_after_inta", low, 3200);

        // FLASH divider from a clean reset
        do_reset();
        step();
        for (int p = 1; p <= 48; p++) begin
            pulse_frame();
            steps(2);
            check("flash_phase", flash, ((m_frames / 16) % 2));
        end
        for (int t = 0; t < 5000 && !n_int; t++) step();
        check("int_idle_before_reset_test", n_int, 1'b1);

        // reset in the middle of an interrupt pulse
        do_write(16'h00FE, 8'h07);
        pulse_frame();
        steps(999);
        check("int_active_pre_reset", n_int, 1'b0);
        reset = 1'b1;
        step();
        check("midrst_n_int", n_int, 1'b1);
        check("midrst_border", border, 3'd0);
        check("midrst_flash", flash, 1'b0);
        reset = 1'b0;
        m_border = 3'd0;
        m_frames = 0;
        steps(3);

        // write strobes held low across reset must not retrigger
        cpu_a = 16'h00FE; cpu_d = 8'h03;
        n_iorq = 1'b0; n_wr = 1'b0;
        steps(5);
        check("held_pre_reset", border, 3'd3);
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        steps(10);
        check("held_after_reset", border, 3'd0);
        bus_idle();
        steps(3);
        n_iorq = 1'b0; n_wr = 1'b0;
        steps(4);
        check("refall_after_reset", border, 3'd3);
        bus_idle();
        steps(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
